// File: rtl/mips_load_store_unit.sv
//------------------------------------------------------------------------------
// mips_load_store_unit : MEM-stage byte/half/word load-store adapter for a
// word-wide data memory, with read-modify-write for sub-word stores.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mips_load_store_unit #(
   parameter int BIG_ENDIAN = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_read,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_address,
   input  logic [31:0] req_wdata,
   output logic        busy,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        addr_err,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_write,
   output logic        mem_read,
   input  logic [31:0] mem_read_data
);

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] wbuf_q, wbuf_d;
   logic [31:0] waddr_q, waddr_d;
   logic [31:0] load_data_q, load_data_d;
   logic        load_valid_q, load_valid_d;
   logic        addr_err_q, addr_err_d;

   logic [31:0] aligned_addr;
   logic [4:0]  lane_shift;
   logic [31:0] lane_mask;
   logic [31:0] merged_word;
   logic [15:0] rd_half;
   logic [31:0] extended;
   logic        misaligned;

   // Lane position of the addressed byte/half within the word.
   always_comb begin
      aligned_addr = {req_address[31:2], 2'b00};
      if (req_size == SIZE_BYTE) begin
         lane_shift = (BIG_ENDIAN != 0) ? {~req_address[1:0], 3'b000}
                                        : { req_address[1:0], 3'b000};
         lane_mask  = 32'h0000_00FF;
      end else begin
         lane_shift = (BIG_ENDIAN != 0) ? {~req_address[1], 4'b0000}
                                        : { req_address[1], 4'b0000};
         lane_mask  = 32'h0000_FFFF;
      end
      merged_word = (mem_read_data & ~(lane_mask << lane_shift))
                  | ((req_wdata & lane_mask) << lane_shift);
      rd_half     = 16'(mem_read_data >> lane_shift);
      case (req_size)
         SIZE_BYTE: extended = req_unsigned ? {24'h000000, rd_half[7:0]}
                                            : {{24{rd_half[7]}}, rd_half[7:0]};
         SIZE_HALF: extended = req_unsigned ? {16'h0000, rd_half}
                                            : {{16{rd_half[15]}}, rd_half};
         default:   extended = mem_read_data;
      endcase
      misaligned = (req_size == 2'b11)
                 | ((req_size == SIZE_HALF) & req_address[0])
                 | ((req_size == SIZE_WORD) & (req_address[1:0] != 2'b00));
   end

   always_comb begin
      state_d        = state_q;
      wbuf_d         = wbuf_q;
      waddr_d        = waddr_q;
      load_data_d    = load_data_q;
      load_valid_d   = 1'b0;
      addr_err_d     = 1'b0;
      busy           = 1'b0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_address    = aligned_addr;
      mem_write_data = wbuf_q;
      case (state_q)
         ST_IDLE: begin
            if (req_read || req_write) begin
               if ((req_read && req_write) || misaligned) begin
                  addr_err_d = 1'b1;
               end else if (req_read) begin
                  mem_read     = 1'b1;
                  load_data_d  = extended;
                  load_valid_d = 1'b1;
               end else if (req_size == SIZE_WORD) begin
                  mem_write      = 1'b1;
                  mem_write_data = req_wdata;
               end else begin
                  // Read phase of RMW: capture the merged word for next cycle.
                  mem_read = 1'b1;
                  wbuf_d   = merged_word;
                  waddr_d  = aligned_addr;
                  state_d  = ST_WRITE;
               end
            end
         end
         ST_WRITE: begin
            busy           = 1'b1;
            mem_write      = 1'b1;
            mem_address    = waddr_q;
            mem_write_data = wbuf_q;
            state_d        = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         wbuf_q       <= 32'h0;
         waddr_q      <= 32'h0;
         load_data_q  <= 32'h0;
         load_valid_q <= 1'b0;
         addr_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         wbuf_q       <= wbuf_d;
         waddr_q      <= waddr_d;
         load_data_q  <= load_data_d;
         load_valid_q <= load_valid_d;
         addr_err_q   <= addr_err_d;
      end
   end

   assign load_data  = load_data_q;
   assign load_valid = load_valid_q;
   assign addr_err   = addr_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_load_store_unit.sv
//------------------------------------------------------------------------------
// tb_mips_load_store_unit : directed bench with word-memory models for a
// big-endian and a little-endian instance.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mips_load_store_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   // Big-endian instance
   logic        rd, wr, uns;
   logic [1:0]  sz;
   logic [31:0] addr, wdata;
   logic        busy, ld_valid, err, mwr, mrd;
   logic [31:0] ld, maddr, mwdata, mrdata;
   logic [31:0] mem_be [0:15];

   // Little-endian instance
   logic        l_rd, l_wr, l_uns;
   logic [1:0]  l_sz;
   logic [31:0] l_addr, l_wdata;
   logic        l_busy, l_ld_valid, l_err, l_mwr, l_mrd;
   logic [31:0] l_ld, l_maddr, l_mwdata, l_mrdata;
   logic [31:0] mem_le [0:15];

   mips_load_store_unit #(.BIG_ENDIAN(1)) u_be (
      .clk(clk), .reset(reset),
      .req_read(rd), .req_write(wr), .req_size(sz), .req_unsigned(uns),
      .req_address(addr), .req_wdata(wdata),
      .busy(busy), .load_data(ld), .load_valid(ld_valid), .addr_err(err),
      .mem_address(maddr), .mem_write_data(mwdata), .mem_write(mwr),
      .mem_read(mrd), .mem_read_data(mrdata)
   );

   mips_load_store_unit #(.BIG_ENDIAN(0)) u_le (
      .clk(clk), .reset(reset),
      .req_read(l_rd), .req_write(l_wr), .req_size(l_sz), .req_unsigned(l_uns),
      .req_address(l_addr), .req_wdata(l_wdata),
      .busy(l_busy), .load_data(l_ld), .load_valid(l_ld_valid), .addr_err(l_err),
      .mem_address(l_maddr), .mem_write_data(l_mwdata), .mem_write(l_mwr),
      .mem_read(l_mrd), .mem_read_data(l_mrdata)
   );

   assign mrdata   = mem_be[maddr[5:2]];
   assign l_mrdata = mem_le[l_maddr[5:2]];
   always @(posedge clk) if (mwr)   mem_be[maddr[5:2]]   <= mwdata;
   always @(posedge clk) if (l_mwr) mem_le[l_maddr[5:2]] <= l_mwdata;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic idle_be();
      rd = 1'b0; wr = 1'b0; sz = 2'b00; uns = 1'b0; addr = 32'h0; wdata = 32'h0;
   endtask

   task automatic idle_le();
      l_rd = 1'b0; l_wr = 1'b0; l_sz = 2'b00; l_uns = 1'b0; l_addr = 32'h0; l_wdata = 32'h0;
   endtask

   typedef struct {
      logic        rd;
      logic        wr;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] addr;
      logic        exp_mrd;
      logic        exp_valid;
      logic        exp_err;
      logic [31:0] exp_ld;
   } vec_t;

   vec_t tbl [11];

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 1'b1, 1'b1, 1'b0, 32'hFFFF_FF88}; // LB
      tbl[1]  = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 1'b1, 1'b1, 1'b0, 32'h0000_00BB}; // LBU
      tbl[2]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 1'b1, 1'b1, 1'b0, 32'hFFFF_AABB}; // LH
      tbl[3]  = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 32'h0000_8899}; // LHU
      tbl[4]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h11, 1'b1, 1'b1, 1'b0, 32'hFFFF_FF99}; // LB
      tbl[5]  = '{1'b1, 1'b0, 2'b10, 1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 32'h8899_AABB}; // LW
      tbl[6]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h12, 1'b0, 1'b0, 1'b1, 32'h8899_AABB}; // LW misaligned
      tbl[7]  = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h12, 1'b1, 1'b1, 1'b0, 32'h0000_00AA}; // LBU
      tbl[8]  = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h13, 1'b0, 1'b0, 1'b1, 32'h0000_00AA}; // SH misaligned
      tbl[9]  = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 1'b0, 1'b0, 1'b1, 32'h0000_00AA}; // reserved size
      tbl[10] = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 1'b0, 1'b0, 1'b1, 32'h0000_00AA}; // read+write

      for (int i = 0; i < 16; i++) begin
         mem_be[i] = 32'h0;
         mem_le[i] = 32'h0;
      end
      mem_be[4] = 32'h8899_AABB;
      mem_le[4] = 32'h8899_AABB;
      idle_be();
      idle_le();

      // Reset state
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rst_busy", busy, 0);
      chk("rst_valid", ld_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_ld", ld, 0);
      chk("rst_mwr", mwr, 0);
      chk("rst_mrd", mrd, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Back-to-back table vectors, one per cycle
      for (int i = 0; i < 11; i++) begin
         rd = tbl[i].rd; wr = tbl[i].wr; sz = tbl[i].sz; uns = tbl[i].uns;
         addr = tbl[i].addr; wdata = 32'h0000_5A5A;
         #1;
         chk($sformatf("v%0d_mrd", i), mrd, tbl[i].exp_mrd);
         chk($sformatf("v%0d_mwr", i), mwr, 0);
         chk($sformatf("v%0d_maddr", i), maddr, {tbl[i].addr[31:2], 2'b00});
         @(posedge clk); #1;
         chk($sformatf("v%0d_valid", i), ld_valid, tbl[i].exp_valid);
         chk($sformatf("v%0d_err", i), err, tbl[i].exp_err);
         chk($sformatf("v%0d_ld", i), ld, tbl[i].exp_ld);
      end
      idle_be();
      @(posedge clk); #1;
      chk("post_err", err, 0);
      chk("post_valid", ld_valid, 0);
      chk("post_mem", mem_be[4], 32'h8899_AABB);

      // SB 0x11 RMW, then load immediately after
      rd = 1'b0; wr = 1'b1; sz = 2'b00; addr = 32'h11; wdata = 32'h0000_0055;
      #1;
      chk("sb_acc_mrd", mrd, 1);
      chk("sb_acc_mwr", mwr, 0);
      chk("sb_acc_busy", busy, 0);
      @(posedge clk); #1;
      chk("sb_wr_busy", busy, 1);
      chk("sb_wr_mwr", mwr, 1);
      chk("sb_wr_mrd", mrd, 0);
      chk("sb_wr_data", mwdata, 32'h8855_AABB);
      chk("sb_wr_addr", maddr, 32'h10);
      @(posedge clk); #1;
      rd = 1'b1; wr = 1'b0; sz = 2'b10; addr = 32'h10; wdata = 32'h0;
      #1;
      chk("lw_busy", busy, 0);
      chk("lw_mrd", mrd, 1);
      @(posedge clk); #1;
      chk("lw_valid", ld_valid, 1);
      chk("lw_ld", ld, 32'h8855_AABB);

      // SH 0x10 followed by SW 0x14 presented while busy
      rd = 1'b0; wr = 1'b1; sz = 2'b01; addr = 32'h10; wdata = 32'h0000_1234;
      @(posedge clk); #1;
      sz = 2'b10; addr = 32'h14; wdata = 32'hDEAD_BEEF;
      #1;
      chk("sh_busy", busy, 1);
      chk("sh_addr", maddr, 32'h10);
      chk("sh_data", mwdata, 32'h1234_AABB);
      @(posedge clk); #1;
      chk("sw_busy", busy, 0);
      chk("sw_mwr", mwr, 1);
      chk("sw_mrd", mrd, 0);
      chk("sw_addr", maddr, 32'h14);
      chk("sw_data", mwdata, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      idle_be();
      #1;
      chk("sw_done_mwr", mwr, 0);
      chk("mem10", mem_be[4], 32'h1234_AABB);
      chk("mem14", mem_be[5], 32'hDEAD_BEEF);

      // Reset during the WRITE cycle of SB 0x10
      @(posedge clk); #1;
      rd = 1'b0; wr = 1'b1; sz = 2'b00; addr = 32'h10; wdata = 32'h0000_00FF;
      @(posedge clk); #1;
      chk("rmw_mwr", mwr, 1);
      #2 reset = 1'b1;
      #1;
      chk("rst_mid_mwr", mwr, 0);
      chk("rst_mid_busy", busy, 0);
      @(posedge clk); #1;
      idle_be();
      reset = 1'b0;
      @(posedge clk); #1;
      chk("rst_mem10", mem_be[4], 32'h1234_AABB);
      chk("rst_ld0", ld, 0);
      chk("rst_after_mwr", mwr, 0);

      // Little-endian instance
      l_rd = 1'b1; l_sz = 2'b00; l_addr = 32'h10;
      @(posedge clk); #1;
      chk("le_lb_valid", l_ld_valid, 1);
      chk("le_lb", l_ld, 32'hFFFF_FFBB);
      l_sz = 2'b01; l_addr = 32'h12;
      @(posedge clk); #1;
      chk("le_lh", l_ld, 32'hFFFF_8899);
      l_rd = 1'b0; l_wr = 1'b1; l_sz = 2'b00; l_addr = 32'h13; l_wdata = 32'h0000_0001;
      @(posedge clk); #1;
      chk("le_sb_busy", l_busy, 1);
      chk("le_sb_data", l_mwdata, 32'h0199_AABB);
      @(posedge clk); #1;
      idle_le();
      #1;
      chk("le_mem10", mem_le[4], 32'h0199_AABB);
      chk("le_busy_end", l_busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
